// File: rtl/sram_pkg.sv
// Shared types and constants for the half-word sequencing SRAM controller.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  localparam int DEF_WAIT_CYCLES = 5;
  localparam int DEF_BASE_ADDR   = 1024;
  localparam int SRAM_AW         = 18;
  localparam int SRAM_DW         = 16;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait counter: done flags the last cycle of a WAIT_CYCLES+1 long phase.
module sram_wait_counter
  import sram_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic done
);

  logic [3:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= r_count + 4'd1;
    end
  end

  assign done = (r_count == 4'(WAIT_CYCLES));

endmodule

// File: rtl/sram_controller.sv
// Splits one 32-bit MEM-stage load/store into two timed half-word accesses
// on the external asynchronous SRAM; ready stays low while the access runs.
module sram_controller
  import sram_pkg::*;
#(
  parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter logic [31:0] BASE_ADDR   = 32'(DEF_BASE_ADDR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N
);

  state_t      r_state;
  state_t      w_next;
  logic        r_is_wr;
  logic [31:0] r_read_data;
  logic        w_req;
  logic        w_cnt_done;
  logic        w_cnt_clear;
  logic        w_cnt_inc;
  logic        w_drive;
  logic        w_upper;
  logic [16:0] w_idx;

  assign w_req = rd_en | wr_en;
  // Word index wraps modulo 2^17; addresses below BASE_ADDR wrap too.
  assign w_idx = 17'((address - BASE_ADDR) >> 2);

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk  (clk),
    .rst  (rst),
    .clear(w_cnt_clear),
    .inc  (w_cnt_inc),
    .done (w_cnt_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_cnt_clear = 1'b1;
    w_cnt_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) w_next = LOW;
      end
      LOW: begin
        w_cnt_inc   = 1'b1;
        w_cnt_clear = w_cnt_done;
        if (w_cnt_done) w_next = HIGH;
      end
      HIGH: begin
        w_cnt_inc   = 1'b1;
        w_cnt_clear = w_cnt_done;
        if (w_cnt_done) w_next = DONE;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Store wins if both requests are raised together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_wr <= 1'b0;
    end else if (r_state == IDLE && w_req) begin
      r_is_wr <= wr_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_read_data <= '0;
    end else if (!r_is_wr && w_cnt_done) begin
      if (r_state == LOW) r_read_data[15:0] <= SRAM_DQ;
      else if (r_state == HIGH) r_read_data[31:16] <= SRAM_DQ;
    end
  end

  assign read_data = r_read_data;
  assign ready     = (r_state == IDLE) ? ~w_req : (r_state == DONE);

  assign w_upper   = (r_state == HIGH) || (r_state == DONE);
  assign w_drive   = r_is_wr && ((r_state == LOW) || (r_state == HIGH));
  assign SRAM_ADDR = {w_idx, w_upper};
  assign SRAM_WE_N = ~w_drive;
  assign SRAM_DQ   = w_drive ? (w_upper ? write_data[31:16] : write_data[15:0]) : 'z;

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: behavioural SRAM models, directed table, corner sequences, random traffic.
module tb_sram_controller;

  localparam int W   = 5;
  localparam int LAT = 2 * W + 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rd_en, wr_en, sel;
  logic [31:0] address, write_data;
  logic        rd0, wr0, rd1, wr1;

  assign rd0 = rd_en & ~sel;
  assign wr0 = wr_en & ~sel;
  assign rd1 = rd_en & sel;
  assign wr1 = wr_en & sel;

  logic [31:0] read_data0, read_data1;
  logic        ready0, ready1;
  wire  [15:0] dq0, dq1;
  logic [17:0] addr0, addr1;
  logic        we0, ub0, lb0, ce0, oe0;
  logic        we1, ub1, lb1, ce1, oe1;

  sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(32'd1024)) dut0 (
    .clk(clk), .rst(rst), .rd_en(rd0), .wr_en(wr0), .address(address),
    .write_data(write_data), .read_data(read_data0), .ready(ready0),
    .SRAM_DQ(dq0), .SRAM_ADDR(addr0), .SRAM_WE_N(we0), .SRAM_UB_N(ub0),
    .SRAM_LB_N(lb0), .SRAM_CE_N(ce0), .SRAM_OE_N(oe0)
  );

  sram_controller #(.WAIT_CYCLES(0), .BASE_ADDR(32'd1024)) dut1 (
    .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(wr1), .address(address),
    .write_data(write_data), .read_data(read_data1), .ready(ready1),
    .SRAM_DQ(dq1), .SRAM_ADDR(addr1), .SRAM_WE_N(we1), .SRAM_UB_N(ub1),
    .SRAM_LB_N(lb1), .SRAM_CE_N(ce1), .SRAM_OE_N(oe1)
  );

  // Behavioural asynchronous SRAMs: drive reads while WE_N is high, latch writes while low.
  logic [15:0] mem0 [0:262143];
  logic [15:0] mem1 [0:262143];
  assign dq0 = we0 ? mem0[addr0] : 16'hzzzz;
  assign dq1 = we1 ? mem1[addr1] : 16'hzzzz;
  always @(posedge clk) if (!we0) mem0[addr0] <= dq0;
  always @(posedge clk) if (!we1) mem1[addr1] <= dq1;

  logic        cur_ready, cur_we;
  logic [31:0] cur_rdata;
  logic [17:0] cur_addr;
  assign cur_ready = sel ? ready1 : ready0;
  assign cur_we    = sel ? we1 : we0;
  assign cur_rdata = sel ? read_data1 : read_data0;
  assign cur_addr  = sel ? addr1 : addr0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h expected %h", name, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    logic [31:0] off;
    off = (a - 32'd1024) >> 2;
    return int'(off & 32'h0001_FFFF);
  endfunction

  // Runs one request from cycle 0 (entered just after a rising edge) until the cycle after ready.
  task automatic do_txn(input bit s, input bit is_wr, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rdat,
                        output logic [17:0] a_lo, output logic [17:0] a_hi, output bit we_glitch);
    int ws;
    ws = s ? 0 : W;
    sel = s; address = a; write_data = d;
    wr_en = is_wr; rd_en = !is_wr;
    lat = -1; rdat = '0; a_lo = '0; a_hi = '0; we_glitch = 1'b0;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (c == 1) a_lo = cur_addr;
      if (c == ws + 2) a_hi = cur_addr;
      if (!is_wr && !cur_we) we_glitch = 1'b1;
      if (cur_ready) begin
        lat = c;
        rdat = cur_rdata;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [17:0] exp_lo;
  } vec_t;

  vec_t vecs [8];
  logic [31:0] model [int];
  logic [31:0] pool [8];

  initial begin
    int lat, lat2, k, gap;
    logic [31:0] rdat, prev, d;
    logic [17:0] a_lo, a_hi;
    bit wg, is_wr;

    vecs[0] = '{1'b1, 32'd1028,   32'hDEADBEEF, 32'h0,        18'd2};
    vecs[1] = '{1'b0, 32'd1028,   32'h0,        32'hDEADBEEF, 18'd2};
    vecs[2] = '{1'b1, 32'd1036,   32'h01020304, 32'h0,        18'd6};
    vecs[3] = '{1'b0, 32'd1036,   32'h0,        32'h01020304, 18'd6};
    vecs[4] = '{1'b1, 32'd525312, 32'hCAFEF00D, 32'h0,        18'd0};
    vecs[5] = '{1'b0, 32'd1024,   32'h0,        32'hCAFEF00D, 18'd0};
    vecs[6] = '{1'b1, 32'd1020,   32'hA5A55A5A, 32'h0,        18'h3FFFE};
    vecs[7] = '{1'b0, 32'd1020,   32'h0,        32'hA5A55A5A, 18'h3FFFE};

    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; sel = 1'b0;
    address = 32'd1024; write_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset_ready0", 32'(ready0), 32'd1);
    check("reset_ready1", 32'(ready1), 32'd1);
    check("reset_rdata0", read_data0, 32'h0);
    check("reset_we0", 32'(we0), 32'd1);
    check("reset_tieoffs", {28'h0, ub0, lb0, ce0, oe0}, 32'h0);
    check("reset_tieoffs1", {28'h0, ub1, lb1, ce1, oe1}, 32'h0);
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      do_txn(1'b0, vecs[i].is_wr, vecs[i].addr, vecs[i].wdata, lat, rdat, a_lo, a_hi, wg);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
      check($sformatf("vec%0d_addr_lo", i), 32'(a_lo), 32'(vecs[i].exp_lo));
      check($sformatf("vec%0d_addr_hi", i), 32'(a_hi), 32'(vecs[i].exp_lo | 18'd1));
      if (vecs[i].is_wr) begin
        check($sformatf("vec%0d_mem_lo", i), 32'(mem0[vecs[i].exp_lo]), 32'(vecs[i].wdata[15:0]));
        check($sformatf("vec%0d_mem_hi", i), 32'(mem0[vecs[i].exp_lo | 18'd1]), 32'(vecs[i].wdata[31:16]));
        model[idx_of(vecs[i].addr)] = vecs[i].wdata;
      end else begin
        check($sformatf("vec%0d_rdata_done", i), rdat, vecs[i].exp_rdata);
        check($sformatf("vec%0d_rdata_after", i), read_data0, vecs[i].exp_rdata);
        check($sformatf("vec%0d_we_quiet", i), 32'(wg), 32'd0);
      end
    end

    // Back-to-back store then load: the load's DONE is cycle 27 of the store's timeline.
    do_txn(1'b0, 1'b1, 32'd1024, 32'h12345678, lat, rdat, a_lo, a_hi, wg);
    do_txn(1'b0, 1'b0, 32'd1024, 32'h0, lat2, rdat, a_lo, a_hi, wg);
    check("b2b_done_cycle", 32'(lat + 1 + lat2), 32'd27);
    check("b2b_rdata", rdat, 32'h12345678);
    model[0] = 32'h12345678;

    // Idle: ready stays high and read_data holds.
    prev = read_data0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #2;
      check("idle_ready", 32'(ready0), 32'd1);
      check("idle_rdata_hold", read_data0, prev);
    end
    @(posedge clk); #1;

    // Reset asserted in cycle 4 of a store.
    sel = 1'b0; address = 32'd1044; write_data = 32'h0BADF00D; wr_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("abort_we_active", 32'(we0), 32'd0);
    rst = 1'b1; wr_en = 1'b0;
    #1;
    check("abort_we_high", 32'(we0), 32'd1);
    check("abort_bus_released", 32'(dq0), 32'(mem0[addr0]));
    check("abort_rdata_clear", read_data0, 32'h0);
    check("abort_idle_ready", 32'(ready0), 32'd1);
    check("abort_addr_low_half", 32'(addr0[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero-wait variant.
    do_txn(1'b1, 1'b1, 32'd1024, 32'h600DCAFE, lat, rdat, a_lo, a_hi, wg);
    check("w0_store_latency", 32'(lat), 32'd3);
    check("w0_mem_lo", 32'(mem1[0]), 32'h0000CAFE);
    check("w0_mem_hi", 32'(mem1[1]), 32'h0000600D);
    do_txn(1'b1, 1'b0, 32'd1024, 32'h0, lat, rdat, a_lo, a_hi, wg);
    check("w0_load_latency", 32'(lat), 32'd3);
    check("w0_load_rdata", rdat, 32'h600DCAFE);
    check("w0_load_addr_hi", 32'(a_hi), 32'd1);
    sel = 1'b0;

    // Random traffic against the word-level reference model.
    for (int i = 0; i < 6; i++) pool[i] = 32'd1024 + 32'(4 * i);
    pool[6] = 32'd1024 + 32'(4 * 131071);
    pool[7] = 32'd1024 + 32'd524288 + 32'd12;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      do_txn(1'b0, 1'b1, pool[i], d, lat, rdat, a_lo, a_hi, wg);
      model[idx_of(pool[i])] = d;
    end
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 7);
      is_wr = 1'($urandom_range(0, 1));
      d = $urandom;
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
      do_txn(1'b0, is_wr, pool[k], d, lat, rdat, a_lo, a_hi, wg);
      check("rnd_latency", 32'(lat), 32'(LAT));
      check("rnd_addr_lo", 32'(a_lo), 32'(idx_of(pool[k]) * 2));
      if (is_wr) begin
        model[idx_of(pool[k])] = d;
        check("rnd_mem_word", {mem0[idx_of(pool[k]) * 2 + 1], mem0[idx_of(pool[k]) * 2]}, d);
      end else begin
        check("rnd_rdata", rdat, model[idx_of(pool[k])]);
        check("rnd_we_quiet", 32'(wg), 32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Sequences one 32-bit load or store from the MEM stage onto the board's external 16-bit asynchronous SRAM as two half-word accesses with a programmable wait count. Sits between the MEM stage and the SRAM pins. Holds `ready` low while an access is in flight; the top level inverts `ready` into the pipeline freeze that stalls every pipeline register and the PC.

## Interface
Parameters:
- `WAIT_CYCLES`, 5: extra cycles each half-word access is held; each half lasts WAIT_CYCLES+1 cycles; legal range 0..15.
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0.

Ports (clock and reset; one clock; reset is asynchronous and active-high):
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.

Ports (MEM-stage side):
- `rd_en` input 1: load request, held until `ready`.
- `wr_en` input 1: store request, held until `ready`.
- `address` input 32: byte address, held stable while a request is pending.
- `write_data` input 32: store data, held stable while a request is pending.
- `read_data` output 32: registered load result.
- `ready` output 1: high when no access is pending, or in the completion cycle.

Ports (SRAM side):
- `SRAM_DQ` inout 16: SRAM data bus; driven only during write phases, high-Z otherwise.
- `SRAM_ADDR` output 18: half-word address.
- `SRAM_WE_N` output 1: active-low write enable.
- `SRAM_UB_N`, `SRAM_LB_N`, `SRAM_CE_N`, `SRAM_OE_N` output 1 each: tied low, both byte lanes always active.

## Operation
- Word index: idx = (address − BASE_ADDR) >> 2, truncated to 17 bits, so addresses wrap modulo 2^17 words. There is no range check.
- Low half-word is at `SRAM_ADDR` = {idx, 0}; high half-word is at {idx, 1}.
- States:
  - IDLE to LOW when (rd_en | wr_en); otherwise stay in IDLE.
  - LOW to HIGH when the wait counter reaches WAIT_CYCLES.
  - HIGH to DONE when the wait counter reaches WAIT_CYCLES.
  - DONE to IDLE, unconditionally.
- Wait counter: 4 bits. It clears on entry to LOW and to HIGH and increments every cycle within a phase.
- The operation is latched on the IDLE-to-LOW transition. If rd_en and wr_en are both high, the store wins (the requester must not do this).
- Store: SRAM_WE_N is low for every cycle of LOW and HIGH. SRAM_DQ drives write_data[15:0] in LOW and write_data[31:16] in HIGH.
- Load: SRAM_WE_N stays high and SRAM_DQ is high-Z. SRAM_DQ is captured into read_data[15:0] on the last LOW cycle and into read_data[31:16] on the last HIGH cycle.
- read_data holds its value until the next load overwrites it. Stores never change it.
- ready = ~(rd_en | wr_en) when in IDLE; 0 in LOW and HIGH; 1 in DONE.
- SRAM_ADDR is {idx, 0} in IDLE and LOW and {idx, 1} in HIGH and DONE. It is derived combinationally from the held `address`.

## Timing
- Reset values: state IDLE, counter 0, read_data 0, SRAM_WE_N 1, SRAM_DQ high-Z. With no request, ready is 1.
- Define cycle 0 as the first cycle a request is seen in IDLE:
  - LOW occupies cycles 1..W+1.
  - HIGH occupies cycles W+2..2W+2.
  - DONE, with ready = 1, is cycle 2W+3.
  - With the default W = 5, ready rises in cycle 13.
- The requester advances on the edge that ends DONE. A new request presented in the following cycle starts immediately, so there is no dead cycle beyond the IDLE cycle.
- Asserting reset mid-access aborts it at once:
  - SRAM_WE_N goes high and the bus is released asynchronously.
  - A partially written word is left undefined in SRAM.
  - read_data clears to 0.
- WAIT_CYCLES = 0 gives 1-cycle phases and ready in cycle 3.

## Structure
- Package `sram_pkg` holds:
  - the state enum (IDLE, LOW, HIGH, DONE);
  - the default BASE_ADDR and WAIT_CYCLES values;
  - the SRAM address width (18) and data width (16).
- One sub-module: `sram_wait_counter`, a 4-bit counter with `clear`, `inc` and a `done` output that compares against WAIT_CYCLES.
- The SRAM_DQ tristate lives in the top-level controller module.

## Test plan
- Store 0xDEADBEEF to byte address 1028 with W = 5:
  - SRAM word 2 = 0xBEEF and word 3 = 0xDEAD in the behavioral SRAM model;
  - ready is low for cycles 0..12 and high in cycle 13.
- Load from 1028 after that store: read_data = 0xDEADBEEF in cycle 14, and SRAM_WE_N stays high throughout.
- Back-to-back requests:
  - store 0x12345678 to 1024, then load from 1024 the cycle after DONE;
  - the load's DONE lands in cycle 27, and read_data = 0x12345678.
- Reset asserted in cycle 4 of a store:
  - SRAM_WE_N goes to 1 and SRAM_DQ goes high-Z within the same cycle;
  - the state is IDLE and read_data = 0.
- Wrap-around and idle behavior:
  - a store to address BASE_ADDR + 4×2^17 hits SRAM_ADDR 0 and 1;
  - with no request, ready is 1 and read_data is unchanged for 20 cycles.
- W = 0 variant: a load from 1024 reaches DONE in cycle 3 with the correct data.
